// File: rtl/csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
//   Control/status register file for the LoongArch core. Consumes committed
//   CSR writes, exception commits and ertn commits from writeback. Provides:
//     - combinational CSR readback to EX
//     - exception entry / ertn return PCs to fetch
//     - the interrupt-pending flag to decode
//   Also contains the constant timer (TCFG/TVAL/TICLR).
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   csr_re, csr_rnum        read enable / address
//   csr_rvalue              combinational read data (0 when csr_re is low)
//   csr_we, csr_num,
//   csr_wvalue              committed write (already mask-merged upstream)
//   excp_flush, ertn_flush  exception / ertn commit this cycle
//   wb_ecode, wb_esubcode,
//   wb_pc                   exception information of the committing instr
//   hw_int_in, ipi_int_in   level-sensitive interrupt lines
//   ex_entry, ertn_pc       EENTRY / ERA to fetch
//   has_int                 enabled interrupt pending
// ---------------------------------------------------------------------------
module csr_regfile #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wvalue,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    localparam logic [31:0] TVAL_IDLE  = 32'hFFFF_FFFF;

    // Architectural state
    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [1:0]  ecfg_lie_hi;     // LIE[12:11]
    logic [9:0]  ecfg_lie_lo;     // LIE[9:0]
    logic [1:0]  estat_is_sw;     // IS[1:0]
    logic [7:0]  estat_is_hw;     // IS[9:2]
    logic        estat_is_timer;  // IS[11]
    logic        estat_is_ipi;    // IS[12]
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry_va;       // EENTRY[31:6]
    logic [31:0] save0, save1, save2, save3;
    logic [31:0] tid;
    logic        tcfg_en;
    logic        tcfg_periodic;
    logic [29:0] tcfg_initval;
    logic [31:0] tval;

    logic [12:0] estat_is;
    logic [12:0] ecfg_lie;
    logic        wr_tcfg;
    logic        ticlr_clear;
    logic        timer_expire;

    assign estat_is     = {estat_is_ipi, estat_is_timer, 1'b0, estat_is_hw, estat_is_sw};
    assign ecfg_lie     = {ecfg_lie_hi, 1'b0, ecfg_lie_lo};
    assign wr_tcfg      = csr_we && (csr_num == CSR_TCFG);
    assign ticlr_clear  = csr_we && (csr_num == CSR_TICLR) && csr_wvalue[0];
    assign timer_expire = tcfg_en && (tval == 32'h0);

    // -----------------------------------------------------------------------
    // Mode, exception and scratch registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch
        // of the clocked block; it is not in the sensitivity list.
        if (reset) begin
            crmd_plv       <= 2'b00;
            crmd_ie        <= 1'b0;
            crmd_da        <= 1'b1;
            prmd_pplv      <= 2'b00;
            prmd_pie       <= 1'b0;
            ecfg_lie_hi    <= 2'b00;
            ecfg_lie_lo    <= 10'h0;
            estat_is_sw    <= 2'b00;
            estat_is_hw    <= 8'h0;
            estat_is_ipi   <= 1'b0;
            estat_ecode    <= 6'h0;
            estat_esubcode <= 9'h0;
            era            <= 32'h0;
            badv           <= 32'h0;
            eentry_va      <= 26'h0;
            save0          <= 32'h0;
            save1          <= 32'h0;
            save2          <= 32'h0;
            save3          <= 32'h0;
            tid            <= TID_RESET;
        end else begin
            // Interrupt lines are level-sensitive and re-sampled every cycle.
            estat_is_hw  <= hw_int_in;
            estat_is_ipi <= ipi_int_in;

            if (csr_we) begin
                unique case (csr_num)
                    CSR_CRMD: begin
                        crmd_plv <= csr_wvalue[1:0];
                        crmd_ie  <= csr_wvalue[2];
                        crmd_da  <= csr_wvalue[3];
                    end
                    CSR_PRMD: begin
                        prmd_pplv <= csr_wvalue[1:0];
                        prmd_pie  <= csr_wvalue[2];
                    end
                    CSR_ECFG: begin
                        ecfg_lie_hi <= csr_wvalue[12:11];
                        ecfg_lie_lo <= csr_wvalue[9:0];
                    end
                    CSR_ESTAT:  estat_is_sw <= csr_wvalue[1:0];
                    CSR_ERA:    era         <= csr_wvalue;
                    CSR_BADV:   badv        <= csr_wvalue;
                    CSR_EENTRY: eentry_va   <= csr_wvalue[31:6];
                    CSR_SAVE0:  save0       <= csr_wvalue;
                    CSR_SAVE1:  save1       <= csr_wvalue;
                    CSR_SAVE2:  save2       <= csr_wvalue;
                    CSR_SAVE3:  save3       <= csr_wvalue;
                    CSR_TID:    tid         <= csr_wvalue;
                    default: ;
                endcase
            end

            // NOTE: these non-blocking assignments come after the software
            // write above; the last NBA to a field wins, so flush updates
            // override a same-cycle write to the same field while untouched
            // fields (e.g. BADV) still take the write.
            if (excp_flush) begin
                prmd_pplv      <= crmd_plv;
                prmd_pie       <= crmd_ie;
                crmd_plv       <= 2'b00;
                crmd_ie        <= 1'b0;
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
                era            <= wb_pc;
            end else if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Constant timer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_en        <= 1'b0;
            tcfg_periodic  <= 1'b0;
            tcfg_initval   <= 30'h0;
            tval           <= TVAL_IDLE;
            estat_is_timer <= 1'b0;
        end else begin
            if (wr_tcfg) begin
                tcfg_en       <= csr_wvalue[0];
                tcfg_periodic <= csr_wvalue[1];
                tcfg_initval  <= csr_wvalue[31:2];
            end

            // A TCFG write takes priority over counting/reload in the same cycle.
            if (wr_tcfg) begin
                tval <= {csr_wvalue[31:2], 2'b00};
            end else if (tcfg_en && (tval != TVAL_IDLE)) begin
                if (tval == 32'h0) begin
                    tval <= tcfg_periodic ? {tcfg_initval, 2'b00} : TVAL_IDLE;
                end else begin
                    tval <= tval - 32'h1;
                end
            end

            // Expiry beats a coincident TICLR clear so no tick is lost.
            if (timer_expire) begin
                estat_is_timer <= 1'b1;
            end else if (ticlr_clear) begin
                estat_is_timer <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Readback and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns csr_rvalue and no latch
        // is inferred for unmapped addresses.
        csr_rvalue = 32'h0;
        if (csr_re) begin
            unique case (csr_rnum)
                CSR_CRMD:   csr_rvalue = {28'h0, crmd_da, crmd_ie, crmd_plv};
                CSR_PRMD:   csr_rvalue = {29'h0, prmd_pie, prmd_pplv};
                CSR_ECFG:   csr_rvalue = {19'h0, ecfg_lie};
                CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b000, estat_is};
                CSR_ERA:    csr_rvalue = era;
                CSR_BADV:   csr_rvalue = badv;
                CSR_EENTRY: csr_rvalue = {eentry_va, 6'h0};
                CSR_SAVE0:  csr_rvalue = save0;
                CSR_SAVE1:  csr_rvalue = save1;
                CSR_SAVE2:  csr_rvalue = save2;
                CSR_SAVE3:  csr_rvalue = save3;
                CSR_TID:    csr_rvalue = tid;
                CSR_TCFG:   csr_rvalue = {tcfg_initval, tcfg_periodic, tcfg_en};
                CSR_TVAL:   csr_rvalue = tval;
                default:    csr_rvalue = 32'h0;
            endcase
        end
    end

    assign ex_entry = {eentry_va, 6'h0};
    assign ertn_pc  = era;
    assign has_int  = crmd_ie & (|(estat_is & ecfg_lie));

endmodule

// File: tb/tb_csr_regfile.sv
// ---------------------------------------------------------------------------
// tb_csr_regfile
//   Self-checking bench for csr_regfile. Expected values are pushed to a
//   scoreboard queue when a read/observation is set up and popped and
//   compared once the DUT output has settled (1 ns into the low clock phase).
// ---------------------------------------------------------------------------
module tb_csr_regfile;

    localparam logic [31:0] TID_INIT = 32'h0000_00A5;

    localparam logic [13:0] A_CRMD   = 14'h0000;
    localparam logic [13:0] A_PRMD   = 14'h0001;
    localparam logic [13:0] A_ECFG   = 14'h0004;
    localparam logic [13:0] A_ESTAT  = 14'h0005;
    localparam logic [13:0] A_ERA    = 14'h0006;
    localparam logic [13:0] A_BADV   = 14'h0007;
    localparam logic [13:0] A_EENTRY = 14'h000C;
    localparam logic [13:0] A_SAVE0  = 14'h0030;
    localparam logic [13:0] A_TID    = 14'h0040;
    localparam logic [13:0] A_TCFG   = 14'h0041;
    localparam logic [13:0] A_TVAL   = 14'h0042;
    localparam logic [13:0] A_TICLR  = 14'h0044;

    logic        clk;
    logic        reset;
    logic        csr_re;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wvalue;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    csr_regfile #(.TID_RESET(TID_INIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_re      (csr_re),
        .csr_rnum    (csr_rnum),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_num     (csr_num),
        .csr_wvalue  (csr_wvalue),
        .excp_flush  (excp_flush),
        .ertn_flush  (ertn_flush),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_pc       (wb_pc),
        .hw_int_in   (hw_int_in),
        .ipi_int_in  (ipi_int_in),
        .ex_entry    (ex_entry),
        .ertn_pc     (ertn_pc),
        .has_int     (has_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_item_t it;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %h, expected an entry", obs);
        end else begin
            it = sb.pop_front();
            check(it.tag, obs, it.exp);
        end
    endtask

    // Combinational CSR read; consumes 1 ns of the low clock phase.
    task automatic rd(input logic [13:0] addr, input logic [31:0] exp, input string tag);
        csr_re   = 1'b1;
        csr_rnum = addr;
        push_exp(tag, exp);
        #1;
        pop_check(csr_rvalue);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [13:0] addr, input logic [31:0] val);
        csr_we     = 1'b1;
        csr_num    = addr;
        csr_wvalue = val;
        @(negedge clk);
        csr_we     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    logic [31:0] estat_hi;   // expected ESTAT Ecode/EsubCode part
    logic [31:0] exp_tval;
    logic        exp_is11;
    logic        ticlr;

    initial begin
        reset       = 1'b1;
        csr_re      = 1'b0;
        csr_rnum    = '0;
        csr_we      = 1'b0;
        csr_num     = '0;
        csr_wvalue  = '0;
        excp_flush  = 1'b0;
        ertn_flush  = 1'b0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_pc       = '0;
        hw_int_in   = '0;
        ipi_int_in  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---- reset state ----
        rd(A_CRMD, 32'h0000_0008, "rst_crmd");
        rd(A_TID,  TID_INIT,      "rst_tid");
        rd(A_TVAL, 32'hFFFF_FFFF, "rst_tval");
        rd(14'h0099, 32'h0,       "unmapped");
        tick();
        rd(A_ERA, 32'h0, "rst_era");
        push_exp("rst_ex_entry", 32'h0); pop_check(ex_entry);
        push_exp("rst_ertn_pc", 32'h0);  pop_check(ertn_pc);
        push_exp("rst_has_int", 32'h0);  pop_check({31'h0, has_int});
        csr_re   = 1'b0;
        csr_rnum = A_CRMD;
        push_exp("re_low", 32'h0);
        #1;
        pop_check(csr_rvalue);
        tick();

        // ---- interrupt line sampling into ESTAT.IS ----
        hw_int_in  = 8'h81;
        ipi_int_in = 1'b1;
        tick();
        rd(A_ESTAT, 32'h0000_1204, "estat_lines");
        hw_int_in  = 8'h00;
        ipi_int_in = 1'b0;
        tick();
        rd(A_ESTAT, 32'h0, "estat_lines_off");
        tick();

        // ---- same-cycle read returns old value, then new value ----
        csr_we = 1'b1; csr_num = A_SAVE0; csr_wvalue = 32'hDEAD_BEEF;
        rd(A_SAVE0, 32'h0, "save0_old");
        tick();
        csr_we = 1'b0;
        rd(A_SAVE0, 32'hDEAD_BEEF, "save0_new");
        for (int i = 0; i < 4; i++) wr(A_SAVE0 + 14'(i), 32'hA5A5_0000 + 32'(i) * 32'h1111);
        for (int i = 0; i < 4; i++) begin
            rd(A_SAVE0 + 14'(i), 32'hA5A5_0000 + 32'(i) * 32'h1111, $sformatf("save%0d", i));
            tick();
        end

        // ---- exception entry and ertn ----
        // DA is written as 1 alongside PLV=3/IE=1, as a mask-merged CRMD write would.
        wr(A_CRMD, 32'h0000_000F);
        rd(A_CRMD, 32'h0000_000F, "crmd_wr");
        excp_flush = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
        tick();
        excp_flush = 1'b0;
        rd(A_CRMD,  32'h0000_0008, "excp_crmd");
        rd(A_PRMD,  32'h0000_0007, "excp_prmd");
        rd(A_ESTAT, 32'h000B_0000, "excp_estat");
        tick();
        rd(A_ERA, 32'h1C00_0100, "excp_era");
        push_exp("excp_ertn_pc", 32'h1C00_0100); pop_check(ertn_pc);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd(A_CRMD, 32'h0000_000F, "ertn_crmd");
        tick();

        // ---- ALE exception with BADV write and a competing ertn ----
        excp_flush = 1'b1; ertn_flush = 1'b1;
        wb_ecode = 6'h09; wb_esubcode = 9'h001; wb_pc = 32'h1C00_0200;
        csr_we = 1'b1; csr_num = A_BADV; csr_wvalue = 32'h8000_0003;
        tick();
        excp_flush = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
        estat_hi = 32'h0049_0000;
        rd(A_BADV,  32'h8000_0003, "ale_badv");
        rd(A_ERA,   32'h1C00_0200, "ale_era");
        rd(A_CRMD,  32'h0000_0008, "excp_beats_ertn");
        rd(A_ESTAT, estat_hi,      "ale_estat");
        tick();

        // ---- ECFG masking, re-enable interrupts ----
        wr(A_CRMD, 32'h0000_000F);
        wr(A_ECFG, 32'hFFFF_FFFF);
        rd(A_ECFG, 32'h0000_1BFF, "ecfg_mask");
        tick();
        wr(A_ECFG, 32'h0000_0800);

        // ---- one-shot timer ----
        wr(A_TCFG, 32'h0000_0011);
        rd(A_TCFG, 32'h0000_0011, "tcfg_rd");
        for (int v = 16; v >= 0; v--) begin
            rd(A_TVAL, 32'(v), $sformatf("oneshot_tval_%0d", v));
            tick();
        end
        rd(A_ESTAT, estat_hi | 32'h0000_0800, "oneshot_is11");
        rd(A_TVAL,  32'hFFFF_FFFF,            "oneshot_wrap");
        push_exp("oneshot_has_int", 32'h1); pop_check({31'h0, has_int});
        tick();
        rd(A_TVAL, 32'hFFFF_FFFF, "oneshot_hold");
        tick();
        wr(A_TICLR, 32'h0000_0001);
        rd(A_ESTAT, estat_hi, "ticlr_is11");
        rd(A_TICLR, 32'h0,    "ticlr_rd");
        push_exp("ticlr_has_int", 32'h0); pop_check({31'h0, has_int});
        tick();

        // ---- periodic timer, TICLR before and exactly at an expiry ----
        wr(A_TCFG, 32'h0000_000B);
        exp_is11 = 1'b0;
        for (int cyc = 0; cyc < 27; cyc++) begin
            exp_tval = 32'(8 - (cyc % 9));
            rd(A_TVAL,  exp_tval, $sformatf("per_tval_c%0d", cyc));
            rd(A_ESTAT, estat_hi | {20'h0, exp_is11, 11'h0}, $sformatf("per_is11_c%0d", cyc));
            ticlr      = (cyc == 12) || (cyc == 17);
            csr_we     = ticlr;
            csr_num    = A_TICLR;
            csr_wvalue = 32'h1;
            tick();
            csr_we = 1'b0;
            if (exp_tval == 32'h0) exp_is11 = 1'b1;
            else if (ticlr)        exp_is11 = 1'b0;
        end
        push_exp("per_has_int", 32'h1); pop_check({31'h0, has_int});

        // ---- EENTRY alignment and reset mid-count ----
        wr(A_EENTRY, 32'h1C00_807F);
        rd(A_EENTRY, 32'h1C00_8040, "eentry_rd");
        push_exp("ex_entry", 32'h1C00_8040); pop_check(ex_entry);
        tick();
        wr(A_TCFG, 32'h0000_0011);
        repeat (3) tick();
        rd(A_TVAL, 32'd13, "mid_tval");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(A_TVAL,   32'hFFFF_FFFF, "mid_rst_tval");
        rd(A_EENTRY, 32'h0,         "mid_rst_eentry");
        rd(A_TCFG,   32'h0,         "mid_rst_tcfg");
        rd(A_CRMD,   32'h0000_0008, "mid_rst_crmd");
        push_exp("mid_rst_ex_entry", 32'h0); pop_check(ex_entry);
        push_exp("mid_rst_ertn_pc", 32'h0);  pop_check(ertn_pc);
        repeat (2) tick();
        rd(A_TVAL,  32'hFFFF_FFFF, "mid_rst_stopped");
        rd(A_ESTAT, 32'h0,         "mid_rst_estat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
